// File: rtl/rf_mp.sv
// rf_mp: multi-read-port register file with post-reset clear sweep and pending-write scoreboard.
// Optional build macro RF_BYPASS_EN forwards same-cycle write data onto matching read ports.
module rf_mp #(
    parameter int DW       = 8,
    parameter int RFW      = 2,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  ready_o,
    input  logic                  we_i,
    input  logic [RFW-1:0]        wr_address_i,
    input  logic [DW-1:0]         wr_data_i,
    input  logic                  rsv_valid_i,
    input  logic [RFW-1:0]        rsv_address_i,
    input  logic [NR*RFW-1:0]     rr_address_i,
    output logic [NR*DW-1:0]      rr_data_o,
    output logic [NR-1:0]         rr_pending_o,
    output logic [(2**RFW)-1:0]   pend_o
);

    localparam int DEPTH = 2**RFW;
    localparam logic [RFW-1:0] LAST_ADDR = RFW'(DEPTH - 1);

    // state    | meaning
    // CLEAR    | sweeping zeros into every entry, ports masked
    // READY    | normal read/write/reserve operation
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]     state_q, state_d;
    logic [RFW-1:0] ctr_q, ctr_d;
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [DW-1:0]  regs_q [DEPTH];

    logic           ready;
    logic           wr_ok;
    logic           rsv_ok;
    logic           mem_we;
    logic [RFW-1:0] mem_addr;
    logic [DW-1:0]  mem_data;

    function automatic logic is_zero_reg(input logic [RFW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign ready  = (state_q == ST_READY);
    assign wr_ok  = ready && we_i && !is_zero_reg(wr_address_i);
    assign rsv_ok = ready && rsv_valid_i && !is_zero_reg(rsv_address_i);

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        case (state_q)
            ST_CLEAR: begin
                ctr_d = ctr_q + 1'b1;
                if (ctr_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    // Reservation is applied after the write so a same-edge reserve wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[wr_address_i] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[rsv_address_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_CLEAR;
            ctr_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            pend_q  <= pend_d;
        end
    end

    // Single storage write port shared by the clear sweep and normal writes.
    assign mem_we   = !ready || wr_ok;
    assign mem_addr = ready ? wr_address_i : ctr_q;
    assign mem_data = ready ? wr_data_i : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we) begin
            regs_q[mem_addr] <= mem_data;
        end
    end

    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [RFW-1:0] rd_addr;
        logic [DW-1:0]  rd_data;
        logic           rd_pend;
        logic           hit;

        assign rd_addr = rr_address_i[k*RFW +: RFW];
`ifdef RF_BYPASS_EN
        assign hit = wr_ok && (rd_addr == wr_address_i);
`else
        assign hit = 1'b0;
`endif

        always_comb begin
            rd_data = '0;
            rd_pend = 1'b0;
            if (ready && !is_zero_reg(rd_addr)) begin
                if (hit) begin
                    rd_data = wr_data_i;
                    rd_pend = 1'b0;
                end else begin
                    rd_data = regs_q[rd_addr];
                    rd_pend = pend_q[rd_addr];
                end
            end
        end

        assign rr_data_o[k*DW +: DW] = rd_data;
        assign rr_pending_o[k]       = rd_pend;
    end

    assign ready_o = ready;
    assign pend_o  = ready ? pend_q : '0;

endmodule

// File: tb/tb_rf_mp.sv
// Self-checking bench for rf_mp: default 8x4x2 instance plus a 16-bit, 8-entry, 3-port instance.
module tb_rf_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_m, ready_m, we_m, rsv_m;
    logic [1:0]  wa_m, ra_m;
    logic [7:0]  wd_m;
    logic [3:0]  rra_m;
    logic [15:0] rrd_m;
    logic [1:0]  rrp_m;
    logic [3:0]  pend_m;

    logic        rst_p, ready_p, we_p, rsv_p;
    logic [2:0]  wa_p, ra_p;
    logic [15:0] wd_p;
    logic [8:0]  rra_p;
    logic [47:0] rrd_p;
    logic [2:0]  rrp_p;
    logic [7:0]  pend_p;

    rf_mp #(.DW(8), .RFW(2), .NR(2), .ZERO_REG(1)) u_m (
        .clk_i(clk), .rst_i(rst_m), .ready_o(ready_m),
        .we_i(we_m), .wr_address_i(wa_m), .wr_data_i(wd_m),
        .rsv_valid_i(rsv_m), .rsv_address_i(ra_m),
        .rr_address_i(rra_m), .rr_data_o(rrd_m), .rr_pending_o(rrp_m), .pend_o(pend_m)
    );

    rf_mp #(.DW(16), .RFW(3), .NR(3), .ZERO_REG(1)) u_p (
        .clk_i(clk), .rst_i(rst_p), .ready_o(ready_p),
        .we_i(we_p), .wr_address_i(wa_p), .wr_data_i(wd_p),
        .rsv_valid_i(rsv_p), .rsv_address_i(ra_p),
        .rr_address_i(rra_p), .rr_data_o(rrd_p), .rr_pending_o(rrp_p), .pend_o(pend_p)
    );

    int checks = 0;
    int failures = 0;
    string       tag_q[$];
    logic [63:0] exp_q[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 64'(exp_q.size()), 64'd1);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_val(t, obs, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts rising edges until ready; stimulus held during the sweep is dropped once ready.
    task automatic m_sweep(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!ready_m && n < 40);
        we_m  = 1'b0;
        rsv_m = 1'b0;
        sb_push(tag, 64'd4);
        sb_pop(64'(n));
    endtask

    task automatic m_all_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            rra_m = {2'(i), 2'(i)};
            #1;
            sb_push({tag, "_data"}, 64'h0);
            sb_pop(64'(rrd_m));
            sb_push({tag, "_pend"}, 64'h0);
            sb_pop(64'(rrp_m));
        end
        sb_push({tag, "_pendvec"}, 64'h0);
        sb_pop(64'(pend_m));
    endtask

    task automatic m_write(input logic [1:0] a, input logic [7:0] d);
        we_m = 1'b1; wa_m = a; wd_m = d;
        step();
        we_m = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_m = 1'b1; we_m = 1'b0; rsv_m = 1'b0; wa_m = '0; ra_m = '0; wd_m = '0; rra_m = '0;
        rst_p = 1'b1; we_p = 1'b0; rsv_p = 1'b0; wa_p = '0; ra_p = '0; wd_p = '0; rra_p = '0;
        step();
        step();

        rra_m = {2'd1, 2'd2};
        #1;
        sb_push("rst_ready", 64'h0);  sb_pop(64'(ready_m));
        sb_push("rst_pend", 64'h0);   sb_pop(64'(pend_m));
        sb_push("rst_rrdata", 64'h0); sb_pop(64'(rrd_m));
        sb_push("rst_rrpend", 64'h0); sb_pop(64'(rrp_m));

        rst_m = 1'b0;
        m_sweep("clear_lat_first");

        m_write(2'd1, 8'hAA);
        m_write(2'd2, 8'hBB);
        m_write(2'd3, 8'hCC);
        rra_m = {2'd3, 2'd1};
        #1;
        sb_push("preload", 64'hCCAA); sb_pop(64'(rrd_m));

        rst_m = 1'b1;
        step();
        rst_m = 1'b0;
        sb_push("pulse_ready", 64'h0); sb_pop(64'(ready_m));
        m_sweep("clear_lat_pulse");
        m_all_zero("cleared");

        m_write(2'd2, 8'h5A);
        rra_m = {2'd2, 2'd2};
        #1;
        sb_push("wr_r2_both", 64'h5A5A); sb_pop(64'(rrd_m));

        m_write(2'd0, 8'h33);
        rra_m = {2'd0, 2'd0};
        #1;
        sb_push("wr_r0_dropped", 64'h0); sb_pop(64'(rrd_m));

        rsv_m = 1'b1; ra_m = 2'd3;
        step();
        rsv_m = 1'b0;
        rra_m = {2'd3, 2'd3};
        #1;
        sb_push("rsv_r3_pend", 64'h8);    sb_pop(64'(pend_m));
        sb_push("rsv_r3_rrpend", 64'h3);  sb_pop(64'(rrp_m));

        m_write(2'd3, 8'h11);
        #1;
        sb_push("wr_r3_pend", 64'h0);     sb_pop(64'(pend_m));
        sb_push("wr_r3_data", 64'h1111);  sb_pop(64'(rrd_m));

        we_m = 1'b1; wa_m = 2'd1; wd_m = 8'h22; rsv_m = 1'b1; ra_m = 2'd1;
        step();
        we_m = 1'b0; rsv_m = 1'b0;
        rra_m = {2'd2, 2'd1};
        #1;
        sb_push("rsvwr_r1_data", 64'h5A22); sb_pop(64'(rrd_m));
        sb_push("rsvwr_r1_pend", 64'h2);    sb_pop(64'(pend_m));
        sb_push("rsvwr_r1_rrp", 64'h1);     sb_pop(64'(rrp_m));

        rsv_m = 1'b1; ra_m = 2'd1;
        step();
        ra_m = 2'd0;
        step();
        rsv_m = 1'b0;
        sb_push("rsv_again_r0_drop", 64'h2); sb_pop(64'(pend_m));

        we_m = 1'b1; wa_m = 2'd2; wd_m = 8'h01; rsv_m = 1'b1; ra_m = 2'd2;
        step();
        rsv_m = 1'b0;
        wd_m  = 8'h7E;
        rra_m = {2'd1, 2'd2};
        #1;
`ifdef RF_BYPASS_EN
        sb_push("byp_same_data", 64'h7E); sb_pop(64'(rrd_m[7:0]));
        sb_push("byp_same_rrp", 64'h0);   sb_pop(64'(rrp_m[0]));
`else
        sb_push("byp_same_data", 64'h01); sb_pop(64'(rrd_m[7:0]));
        sb_push("byp_same_rrp", 64'h1);   sb_pop(64'(rrp_m[0]));
`endif
        sb_push("byp_other_port", 64'h22); sb_pop(64'(rrd_m[15:8]));
        step();
        we_m = 1'b0;
        #1;
        sb_push("byp_next_data", 64'h7E); sb_pop(64'(rrd_m[7:0]));
        sb_push("byp_next_rrp", 64'h0);   sb_pop(64'(rrp_m[0]));

        rst_m = 1'b1;
        step();
        rst_m = 1'b0;
        we_m = 1'b1; wa_m = 2'd1; wd_m = 8'h55; rsv_m = 1'b1; ra_m = 2'd2;
        rra_m = {2'd1, 2'd1};
        step();
        sb_push("sweep_masked", 64'h0); sb_pop(64'(rrd_m));
        step();
        rst_m = 1'b1;
        step();
        rst_m = 1'b0;
        sb_push("mid_ready", 64'h0); sb_pop(64'(ready_m));
        m_sweep("clear_lat_mid");
        m_all_zero("mid_cleared");

        rst_p = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!ready_p && n < 40);
        sb_push("p_clear_lat", 64'd8); sb_pop(64'(n));

        we_p = 1'b1;
        wa_p = 3'd5; wd_p = 16'hBEEF; step();
        wa_p = 3'd6; wd_p = 16'h1234; step();
        wa_p = 3'd7; wd_p = 16'hCAFE; step();
        wa_p = 3'd0; wd_p = 16'hFFFF; step();
        we_p = 1'b0;
        rsv_p = 1'b1; ra_p = 3'd4; step();
        rsv_p = 1'b0;
        rra_p = {3'd7, 3'd6, 3'd5};
        #1;
        sb_push("p_port0", 64'hBEEF); sb_pop(64'(rrd_p[15:0]));
        sb_push("p_port1", 64'h1234); sb_pop(64'(rrd_p[31:16]));
        sb_push("p_port2", 64'hCAFE); sb_pop(64'(rrd_p[47:32]));
        sb_push("p_pend", 64'h10);    sb_pop(64'(pend_p));
        rra_p = {3'd4, 3'd0, 3'd6};
        #1;
        sb_push("p_mix_data", 64'h000000001234); sb_pop(64'(rrd_p));
        sb_push("p_mix_rrp", 64'h4);             sb_pop(64'(rrp_p));

        check_val("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
